i2c_mem_arbiter: RTL and testbench
==================================

Name: i2c_mem_arbiter

Overview:
- Master-side sequencer and round-robin arbiter sharing the I2C-style memory controller slave between NUM_REQ requesters.
- Latches one requester's command and serialises it onto SCL/SDA_OUT: start, 7 address bits LSB-first, R/W bit, ack sample, 8 data bits (write), stop.
- Returns read data or error to the granted requester.
- Sits between client logic and the memorycontroller slave port of mainbus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 7, memory address width
- DATA_WIDTH, 8, memory data width
- TIMEOUT, 16, max cycles waiting for mem_done on reads
- MAX_RETRY, 2, NACK retries (used only with RETRY_ON_NACK_EN)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester request level
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  NACK or timeout, valid with rsp_valid
- rsp_id  out  $clog2(NUM_REQ)  granted requester index
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and on error
- SCL  out  1  serial clock line to slave
- SDA_OUT  out  1  serial data line to slave
- slv_reset_n  out  1  slave reset pulse
- ack_n  in  1  slave acknowledge, active-low
- mem_done  in  1  slave read-complete
- mem_data_out  in  DATA_WIDTH  slave read data

Behaviour:
- Reset values:
  - SCL=1, SDA_OUT=1, slv_reset_n=1
  - gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_rdata=0
  - rr pointer=0, state=IDLE
- All outputs are registered.
- Reset mid-transaction: all outputs return to reset values on the same edge. No rsp_valid is issued for the aborted request.
- Arbitration (IDLE only):
  - Round-robin starting at the pointer.
  - On grant at edge E0: latch addr/we/wdata/id, set gnt one-hot, pointer = granted+1 mod NUM_REQ.
  - req dropped before grant is ignored. Changes to req fields after grant are ignored.
- States, one cycle each unless noted:
  - SRST: slv_reset_n=0.
  - SREL: slv_reset_n=1.
  - ST1: SCL=1, SDA=1.
  - ST0: SDA=0.
  - ADDR×7: SDA=addr[0..6].
  - RW: SDA=we.
  - ACK: sample ack_n at end of cycle.
  - Write path: GAP×2 (SDA held), DATA×8 (SDA=wdata[0..7]), ACK2 (sample ack_n), SP0 (SCL=1, SDA=0), SP1 (SDA=1), RESP.
  - Read path: SP0, SP1, WAITD, RESP.
  - WAITD: wait for mem_done=1. Capture mem_data_out on the cycle it is seen, then go to RESP. After TIMEOUT cycles without mem_done: error, rdata=0.
  - NACK (ack_n=1) at ACK or ACK2: skip remaining bits, go SP0→SP1→RESP with rsp_err=1. Stop is always issued.
- RESP: rsp_valid=1 for one cycle. gnt clears at the end of RESP, then IDLE. At least one IDLE cycle separates transactions.
- Latency, fixed:
  - Write: rsp_valid at E0+26.
  - Read: rsp_valid at E0+16 minimum, E0+15+TIMEOUT+1 maximum.
- Bit counters are 3-bit and wrap only via explicit state exit. Never index beyond ADDR_WIDTH-1 or DATA_WIDTH-1.

Optional Feature:
- RETRY_ON_NACK_EN defined:
  - NACK at ACK or ACK2 issues the stop, then restarts at SRST with the same latched command.
  - Up to MAX_RETRY retries; rsp_err=1 only after the final NACK.
  - gnt held throughout.
- Undefined: the first NACK returns rsp_err=1.

Decomposition:
- Package i2c_mem_arb_pkg:
  - state enum
  - RW_WRITE=1, RW_READ=0
  - default ADDR_WIDTH and DATA_WIDTH
  - GAP_CYCLES=2
- Sub-module rr_arbiter: NUM_REQ round-robin grant with pointer. Purely combinational select plus registered pointer-update input.

Test Plan:
- Write, req0, addr=7'h55, wdata=8'hA5, ack_n=0:
  - SDA address bits 1,0,1,0,1,0,1; RW=1; data bits 1,0,1,0,0,1,0,1.
  - rsp_valid at E0+26, err=0, id=0.
- Read, req1, addr=100; slave asserts mem_done with 8'h3C on the first WAITD cycle:
  - rsp_rdata=8'h3C, err=0, id=1, rsp_valid at E0+16.
- req0 and req2 held high continuously from reset:
  - Grant order 0,2,0,2; never two gnt bits set.
- ack_n=1 at ACK on a write:
  - No DATA cycles; stop SCL=1 with SDA 0→1; rsp_err=1.
  - With RETRY_ON_NACK_EN: 3 start sequences observed, then err=1.
- Read with mem_done stuck low:
  - rsp_valid at E0+32, err=1, rdata=0.
- reset_n low during DATA bit 4:
  - Next edge SCL=1, SDA=1, gnt=0, no rsp_valid.
  - A following write to addr 3 completes with err=0.

Source files
------------

// File: rtl/i2c_mem_arb_pkg.sv
// Shared types and constants for the I2C memory arbiter.
// Optional NACK retry in the top is enabled by defining RETRY_ON_NACK_EN.
package i2c_mem_arb_pkg;

  typedef enum logic [3:0] {
    StIdle, StSrst, StSrel, StSt1, StSt0, StAddr, StRw, StAck,
    StGap, StData, StAck2, StSp0, StSp1, StWaitd, StResp
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 7;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned GAP_CYCLES         = 2;

  // Bits serialised on the wire, independent of the parameterised widths.
  localparam logic [2:0] ADDR_LAST_BIT = 3'd6;
  localparam logic [2:0] DATA_LAST_BIT = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select starting at a registered pointer; the pointer
// moves past the winner on the cycle the grant is taken.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       update,
  output logic                       any_req,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0] ptr_q;
  int unsigned    idx;

  always_comb begin
    any_req  = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      idx = (32'(ptr_q) + j) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req  = 1'b1;
        grant_id = IdW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (update) begin
      ptr_q <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_mem_arbiter.sv
// Arbitrates NUM_REQ clients onto the I2C-style memory slave and serialises one command at a time.
// Define RETRY_ON_NACK_EN to restart a NACKed command up to MAX_RETRY times before reporting error.
module i2c_mem_arbiter
  import i2c_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          SCL,
  output logic                          SDA_OUT,
  output logic                          slv_reset_n,
  input  logic                          ack_n,
  input  logic                          mem_done,
  input  logic [DATA_WIDTH-1:0]         mem_data_out
);
  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  state_e                  state_q;
  logic [2:0]              bit_cnt;
  logic [WaitW-1:0]        wait_cnt;
  logic [RetryW-1:0]       retry_cnt;
  logic [IdW-1:0]          id_q;
  logic                    we_q, err_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_sh;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_sh;
  logic                    any_req, retry_en;
  logic [IdW-1:0]          grant_id;

`ifdef RETRY_ON_NACK_EN
  assign retry_en = 1'b1;
`else
  assign retry_en = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .update   (state_q == StIdle && any_req),
    .any_req  (any_req),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      gnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata   <= '0;
      SCL         <= 1'b1;
      SDA_OUT     <= 1'b1;
      slv_reset_n <= 1'b1;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      retry_cnt   <= '0;
      id_q        <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      addr_sh     <= '0;
      wdata_q     <= '0;
      wdata_sh    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: if (any_req) begin
          id_q        <= grant_id;
          we_q        <= req_we[grant_id];
          addr_q      <= req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q     <= req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
          gnt         <= NUM_REQ'(1) << grant_id;
          retry_cnt   <= '0;
          err_q       <= 1'b0;
          slv_reset_n <= 1'b0;
          state_q     <= StSrst;
        end
        StSrst: begin
          slv_reset_n <= 1'b1;
          state_q     <= StSrel;
        end
        StSrel: begin
          SCL     <= 1'b1;
          SDA_OUT <= 1'b1;
          state_q <= StSt1;
        end
        StSt1: begin
          SDA_OUT  <= 1'b0;
          addr_sh  <= addr_q;
          wdata_sh <= wdata_q;
          state_q  <= StSt0;
        end
        StSt0: begin
          SCL     <= 1'b0;
          SDA_OUT <= addr_sh[0];
          addr_sh <= addr_sh >> 1;
          bit_cnt <= '0;
          state_q <= StAddr;
        end
        StAddr: if (bit_cnt == ADDR_LAST_BIT) begin
          SDA_OUT <= we_q;
          state_q <= StRw;
        end else begin
          SDA_OUT <= addr_sh[0];
          addr_sh <= addr_sh >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        StRw: begin
          SDA_OUT <= 1'b1;  // release for the slave ACK
          state_q <= StAck;
        end
        StAck: if (!ack_n && we_q == RW_WRITE) begin
          bit_cnt <= '0;
          state_q <= StGap;
        end else begin
          err_q   <= ack_n;
          SCL     <= 1'b1;
          SDA_OUT <= 1'b0;
          state_q <= StSp0;
        end
        StGap: if (bit_cnt == 3'(GAP_CYCLES - 1)) begin
          SDA_OUT  <= wdata_sh[0];
          wdata_sh <= wdata_sh >> 1;
          bit_cnt  <= '0;
          state_q  <= StData;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        StData: if (bit_cnt == DATA_LAST_BIT) begin
          SDA_OUT <= 1'b1;
          state_q <= StAck2;
        end else begin
          SDA_OUT  <= wdata_sh[0];
          wdata_sh <= wdata_sh >> 1;
          bit_cnt  <= bit_cnt + 1'b1;
        end
        StAck2: begin
          err_q   <= ack_n;
          SCL     <= 1'b1;
          SDA_OUT <= 1'b0;
          state_q <= StSp0;
        end
        StSp0: begin
          SDA_OUT <= 1'b1;
          state_q <= StSp1;
        end
        StSp1: if (err_q && retry_en && 32'(retry_cnt) < MAX_RETRY) begin
          retry_cnt   <= retry_cnt + 1'b1;
          err_q       <= 1'b0;
          slv_reset_n <= 1'b0;
          state_q     <= StSrst;
        end else if (!err_q && we_q == RW_READ) begin
          wait_cnt <= '0;
          state_q  <= StWaitd;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_id    <= id_q;
          rsp_rdata <= '0;
          state_q   <= StResp;
        end
        StWaitd: if (mem_done || 32'(wait_cnt) == TIMEOUT) begin
          rsp_valid <= 1'b1;
          rsp_err   <= !mem_done;
          rsp_id    <= id_q;
          rsp_rdata <= mem_done ? mem_data_out : '0;
          state_q   <= StResp;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        StResp: begin
          gnt       <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Bench for i2c_mem_arbiter: timeline model of the serial protocol checked every cycle,
// plus literal expectations for the directed scenarios; honours RETRY_ON_NACK_EN.
module tb_i2c_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 16;
`ifdef RETRY_ON_NACK_EN
  localparam int MAXR = 2;
`else
  localparam int MAXR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req, req_we, gnt;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err, SCL, SDA_OUT, slv_reset_n, ack_n, mem_done;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_rdata, mem_data_out;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  i2c_mem_arbiter #(
    .NUM_REQ (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .TIMEOUT (TO), .MAX_RETRY (2)
  ) dut (
    .clk (clk), .reset_n (reset_n), .req (req), .req_we (req_we), .req_addr (req_addr),
    .req_wdata (req_wdata), .gnt (gnt), .rsp_valid (rsp_valid), .rsp_err (rsp_err),
    .rsp_id (rsp_id), .rsp_rdata (rsp_rdata), .SCL (SCL), .SDA_OUT (SDA_OUT),
    .slv_reset_n (slv_reset_n), .ack_n (ack_n), .mem_done (mem_done),
    .mem_data_out (mem_data_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected {SCL, SDA, slv_reset_n} a cycles after an attempt starts.
  function automatic logic [2:0] lines(int a, logic we, logic nack1, logic [AW-1:0] addr,
                                       logic [DW-1:0] wd);
    if (a == 0) return 3'b110;
    if (a <= 2) return 3'b111;
    if (a == 3) return 3'b101;
    if (a <= 10) return {1'b0, addr[a-4], 1'b1};
    if (a == 11) return {1'b0, we, 1'b1};
    if (a == 12) return 3'b011;
    if (we && !nack1) begin
      if (a <= 14 || a == 23) return 3'b011;
      if (a <= 22) return {1'b0, wd[a-15], 1'b1};
      if (a == 24) return 3'b101;
      return 3'b111;
    end
    if (a == 13) return 3'b101;
    return 3'b111;
  endfunction

  // Reference model: one transaction as a timeline of cycle offsets from the grant edge.
  bit            m_busy, m_we, nack1, nackd, found;
  int            m_ptr, m_id, k, base, resp_k, end_a, tries, ma, mi;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [N-1:0]  e_gnt;
  logic          e_valid, e_err, e_scl, e_sda, e_slv;
  logic [DW-1:0] e_rdata;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 0; m_ptr = 0; e_gnt = '0; e_valid = 0; e_err = 0; e_rdata = '0;
      {e_scl, e_sda, e_slv} = 3'b111;
    end else if (!m_busy) begin
      e_valid = 0; e_gnt = '0; {e_scl, e_sda, e_slv} = 3'b111;
      found = 0;
      for (int j = 0; j < N; j++) begin
        mi = (m_ptr + j) % N;
        if (!found && req[mi]) begin found = 1; m_id = mi; end
      end
      if (found) begin
        m_busy = 1; m_we = req_we[m_id];
        m_addr = req_addr[m_id*AW +: AW]; m_wdata = req_wdata[m_id*DW +: DW];
        m_ptr = (m_id + 1) % N; k = 0; base = 0; resp_k = -1; end_a = -1;
        nack1 = 0; nackd = 0; tries = 0;
        e_gnt = N'(1 << m_id);
        {e_scl, e_sda, e_slv} = lines(0, m_we, 0, m_addr, m_wdata);
      end
    end else if (resp_k >= 0) begin
      m_busy = 0; e_gnt = '0; e_valid = 0; {e_scl, e_sda, e_slv} = 3'b111;
    end else begin
      k++; ma = k - base;
      if (ma == 13) begin
        if (ack_n) begin nack1 = 1; nackd = 1; end_a = 15; end
        else if (m_we) end_a = 26;
      end
      if (ma == 24 && m_we && !nack1 && ack_n) nackd = 1;
      if (ma == end_a) begin
        if (nackd && tries < MAXR) begin
          tries++; base = k; ma = 0; nack1 = 0; nackd = 0; end_a = -1;
        end else begin
          resp_k = k; e_err = nackd; e_rdata = '0;
        end
      end else if (!m_we && !nack1 && ma >= 16) begin
        if (mem_done) begin resp_k = k; e_err = 0; e_rdata = mem_data_out; end
        else if (ma == 16 + TO) begin resp_k = k; e_err = 1; e_rdata = '0; end
      end
      e_valid = (resp_k == k);
      if (e_valid) {e_scl, e_sda, e_slv} = 3'b111;
      else {e_scl, e_sda, e_slv} = lines(ma, m_we, nack1, m_addr, m_wdata);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      if (e_valid) begin
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      end
      chk("scl_sda_slvrst", 32'({SCL, SDA_OUT, slv_reset_n}), 32'({e_scl, e_sda, e_slv}));
    end
  end

  // Directed transaction: single requester, trace of the lines from the grant edge on.
  logic          tr_scl [64];
  logic          tr_sda [64];
  int            n_starts, lat;
  logic          r_err;
  int            r_id;
  logic [DW-1:0] r_rdata;

  task automatic txn(input int id, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic nack, input int md_at);
    req_we[id] = we; req_addr[id*AW +: AW] = addr; req_wdata[id*DW +: DW] = wd;
    req[id] = 1'b1; ack_n = nack; mem_data_out = 8'h3C;
    lat = -1; n_starts = 0;
    @(posedge clk);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (n == 0) req[id] = 1'b0;
      tr_scl[n] = SCL; tr_sda[n] = SDA_OUT;
      if (n > 0 && tr_scl[n] && tr_scl[n-1] && tr_sda[n-1] && !tr_sda[n]) n_starts++;
      mem_done = (n == md_at);
      if (rsp_valid) begin
        lat = n; r_err = rsp_err; r_id = 32'(rsp_id); r_rdata = rsp_rdata;
        break;
      end
    end
    mem_done = 1'b0; ack_n = 1'b0;
    @(negedge clk);
  endtask

  logic [AW-1:0] ab;
  logic [DW-1:0] db;
  int            nlow;
  int            rr_ids[$];

  initial begin
    reset_n = 0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ack_n = 0; mem_done = 0; mem_data_out = '0;
    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_lines", 32'({SCL, SDA_OUT, slv_reset_n}), 32'(3'b111));
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_id, rsp_rdata}), 0);
    reset_n = 1;

    // Write 0x55 <- 0xA5 from requester 0.
    txn(0, 1'b1, 7'h55, 8'hA5, 1'b0, -1);
    for (int i = 0; i < 7; i++) ab[i] = tr_sda[4+i];
    for (int i = 0; i < 8; i++) db[i] = tr_sda[15+i];
    chk("w_lat", 32'(lat), 26);
    chk("w_err", 32'(r_err), 0);
    chk("w_id", 32'(r_id), 0);
    chk("w_addr_bits", 32'(ab), 32'h55);
    chk("w_rw_bit", 32'(tr_sda[11]), 1);
    chk("w_data_bits", 32'(db), 32'hA5);
    chk("w_start", 32'({tr_scl[2], tr_sda[2], tr_scl[3], tr_sda[3]}), 32'b1110);
    chk("w_stop", 32'({tr_scl[24], tr_sda[24], tr_scl[25], tr_sda[25]}), 32'b1011);

    // Read address 100 from requester 1, data ready on the first wait cycle.
    txn(1, 1'b0, 7'd100, 8'h00, 1'b0, 15);
    chk("r_lat", 32'(lat), 16);
    chk("r_rdata", 32'(r_rdata), 32'h3C);
    chk("r_err", 32'(r_err), 0);
    chk("r_id", 32'(r_id), 1);

    // Write NACKed at the address ACK.
    txn(2, 1'b1, 7'h12, 8'hFF, 1'b1, -1);
    nlow = 0;
    for (int i = 0; i <= lat && i < 64; i++) if (!tr_scl[i]) nlow++;
    chk("nack_lat", 32'(lat), 32'(15 + 15 * MAXR));
    chk("nack_err", 32'(r_err), 1);
    chk("nack_starts", 32'(n_starts), 32'(MAXR + 1));
    chk("nack_scl_low", 32'(nlow), 32'(9 * (MAXR + 1)));
    chk("nack_stop", 32'({tr_scl[13], tr_sda[13], tr_scl[14], tr_sda[14]}), 32'b1011);

    // Read with mem_done never arriving.
    txn(3, 1'b0, 7'h01, 8'h00, 1'b0, -1);
    chk("to_lat", 32'(lat), 32);
    chk("to_err", 32'(r_err), 1);
    chk("to_rdata", 32'(r_rdata), 0);

    // Reset during data bit 4 of a write.
    req_we[0] = 1'b1; req_addr[0 +: AW] = 7'h2A; req_wdata[0 +: DW] = 8'h0F; req[0] = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 21; n++) begin
      @(negedge clk);
      if (n == 0) req[0] = 1'b0;
      if (n == 19) reset_n = 0;
      if (n == 20) begin
        chk("mid_rst_lines", 32'({SCL, SDA_OUT, rsp_valid}), 32'(3'b110));
        chk("mid_rst_gnt", 32'(gnt), 0);
        reset_n = 1;
      end
    end
    txn(0, 1'b1, 7'd3, 8'h5A, 1'b0, -1);
    chk("post_rst_lat", 32'(lat), 26);
    chk("post_rst_err", 32'(r_err), 0);

    // Requesters 0 and 2 held high from reset.
    reset_n = 0; req = 4'b0101; req_we = '1;
    @(negedge clk);
    reset_n = 1;
    for (int c = 0; c < 200 && rr_ids.size() < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rr_ids.push_back(32'(rsp_id));
    end
    req = '0;
    chk("rr_count", 32'(rr_ids.size()), 4);
    while (rr_ids.size() < 4) rr_ids.push_back(-1);
    chk("rr_order", {8'(rr_ids[0]), 8'(rr_ids[1]), 8'(rr_ids[2]), 8'(rr_ids[3])},
        32'h00020002);
    for (int c = 0; c < 40 && m_busy; c++) @(negedge clk);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset_n      = ($urandom_range(0, 699) != 0);
      req          = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      req_we       = N'($urandom);
      req_addr     = (N*AW)'($urandom);
      req_wdata    = (N*DW)'($urandom);
      ack_n        = ($urandom_range(0, 9) == 0);
      mem_done     = ($urandom_range(0, 5) == 0);
      mem_data_out = DW'($urandom);
    end
    reset_n = 1; req = '0; ack_n = 0; mem_done = 0;
    for (int c = 0; c < 120 && m_busy; c++) @(negedge clk);
    chk("drain_idle", 32'(m_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
